// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: memory command/size/address/data
// types, the arbiter FSM state enum and a saturating-increment helper.
package mem_port_arbiter_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] ADDR;
    typedef logic [XLEN-1:0] DATA;
    typedef logic [1:0]      MEM_SIZE;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } MEM_COMMAND;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_BUSY = 2'd1,
        LD_BUSY = 2'd2,
        DRAINED = 2'd3
    } ARB_STATE;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_store_credit_counter.sv
// Committed-but-unwritten store counter (clamped at SQ_SZ, sticky overflow flag)
// and the saturating load-over-store starvation counter.
module store_credit_counter #(
    parameter int N            = 2,
    parameter int SQ_SZ        = 8,
    parameter int STARVE_LIMIT = 4,
    localparam int NW = $clog2(N + 1),
    localparam int PW = $clog2(SQ_SZ + 1),
    localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [NW-1:0] i_num_retiring,
    input  logic          i_st_done,
    input  logic          i_ld_grant,
    input  logic          i_store_ok,
    input  logic          i_st_issue,
    output logic [PW-1:0] o_pending,
    output logic          o_overflow_err,
    output logic [SW-1:0] o_starve_cnt
);

    logic [PW-1:0] r_pending;
    logic          r_overflow_err;
    logic [SW-1:0] r_starve_cnt;
    logic [PW:0]   w_sum;
    logic          w_over;

    // One extra bit of headroom so retire-plus-pending can be compared against SQ_SZ
    always_comb begin
        w_sum  = {1'b0, r_pending} + (PW+1)'(i_num_retiring) - (PW+1)'(i_st_done);
        w_over = (w_sum > (PW+1)'(SQ_SZ));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending      <= '0;
            r_overflow_err <= 1'b0;
            r_starve_cnt   <= '0;
        end else begin
            r_pending <= w_over ? PW'(SQ_SZ) : w_sum[PW-1:0];
            if (w_over) begin
                r_overflow_err <= 1'b1;
            end
            if (i_st_issue) begin
                r_starve_cnt <= '0;
            end else if (i_ld_grant && i_store_ok && (r_starve_cnt < SW'(STARVE_LIMIT))) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
        end
    end

    assign o_pending      = r_pending;
    assign o_overflow_err = r_overflow_err;
    assign o_starve_cnt   = r_starve_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single data-memory port arbiter: committed stores vs speculative loads, halt drain.
// Optional statistics counters are built when MEM_PORT_ARBITER_STATS_EN is defined.
//
// state   | meaning
// IDLE    | port free; arbitrate store vs load, or enter DRAINED after halt
// ST_BUSY | store outstanding, waiting for mem_ack
// LD_BUSY | load outstanding, waiting for mem_ack
// DRAINED | halt retired and every store written; terminal until reset
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N            = 2,
    parameter int SQ_SZ        = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [$clog2(N+1)-1:0]     num_store_retiring,
    input  logic                       halt_retired,
    input  logic                       sq_head_valid,
    input  logic [31:0]                sq_head_addr,
    input  logic [31:0]                sq_head_data,
    input  logic [1:0]                 sq_head_size,
    output logic                       sq_pop,
    input  logic                       ld_req_valid,
    input  logic [31:0]                ld_req_addr,
    input  logic [1:0]                 ld_req_size,
    output logic                       ld_grant,
    output logic                       ld_data_valid,
    output logic [31:0]                ld_data,
    output logic [1:0]                 mem_command,
    output logic [31:0]                mem_addr,
    output logic [1:0]                 mem_size,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_ack,
    input  logic [31:0]                mem_rdata,
`ifdef MEM_PORT_ARBITER_STATS_EN
    output logic [31:0]                st_issued,
    output logic [31:0]                ld_issued,
    output logic [31:0]                st_wait_cycles,
`endif
    output logic [$clog2(SQ_SZ+1)-1:0] pending_stores,
    output logic                       drained,
    output logic                       overflow_err
);

    localparam int PW = $clog2(SQ_SZ + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    ARB_STATE   r_state;
    ARB_STATE   w_state_next;
    MEM_COMMAND r_cmd;
    ADDR        r_addr;
    MEM_SIZE    r_size;
    DATA        r_wdata;
    DATA        r_ld_data;
    logic       r_ld_data_valid;
    logic       r_halt_seen;
    logic       r_drained;

    logic [PW-1:0] w_pending;
    logic [SW-1:0] w_starve;
    logic          w_overflow;
    logic          w_store_ok;
    logic          w_halt_any;
    logic          w_st_win;
    logic          w_ld_win;
    logic          w_st_done;
    logic          w_ld_done;

    store_credit_counter #(
        .N            (N),
        .SQ_SZ        (SQ_SZ),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_credit (
        .clock          (clock),
        .reset          (reset),
        .i_num_retiring (num_store_retiring),
        .i_st_done      (w_st_done),
        .i_ld_grant     (w_ld_win),
        .i_store_ok     (w_store_ok),
        .i_st_issue     (w_st_win),
        .o_pending      (w_pending),
        .o_overflow_err (w_overflow),
        .o_starve_cnt   (w_starve)
    );

    // A halt committing this cycle already blocks loads: anything younger is wrong-path.
    // Draining waits for the registered flag so same-cycle retiring stores are counted first.
    always_comb begin
        w_store_ok   = (w_pending != '0) && sq_head_valid;
        w_halt_any   = r_halt_seen || halt_retired;
        w_state_next = r_state;
        w_st_win     = 1'b0;
        w_ld_win     = 1'b0;
        w_st_done    = 1'b0;
        w_ld_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_halt_seen && (w_pending == '0)) begin
                    w_state_next = DRAINED;
                end else if (w_store_ok && (!ld_req_valid || (w_starve >= SW'(STARVE_LIMIT)) ||
                                            (w_pending == PW'(SQ_SZ)) || w_halt_any)) begin
                    w_st_win     = 1'b1;
                    w_state_next = ST_BUSY;
                end else if (ld_req_valid && !w_halt_any && reset) begin
                    w_ld_win     = 1'b1;
                    w_state_next = LD_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    w_st_done    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            LD_BUSY: begin
                if (mem_ack) begin
                    w_ld_done    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            DRAINED: w_state_next = DRAINED;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_cmd           <= NONE;
            r_addr          <= '0;
            r_size          <= '0;
            r_wdata         <= '0;
            r_ld_data       <= '0;
            r_ld_data_valid <= 1'b0;
            r_halt_seen     <= 1'b0;
            r_drained       <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_ld_data_valid <= w_ld_done;
            if (w_ld_done) begin
                r_ld_data <= mem_rdata;
            end
            if (halt_retired) begin
                r_halt_seen <= 1'b1;
            end
            if (w_state_next == DRAINED) begin
                r_drained <= 1'b1;
            end
            if (w_st_win) begin
                r_cmd   <= STORE;
                r_addr  <= sq_head_addr;
                r_size  <= sq_head_size;
                r_wdata <= sq_head_data;
            end else if (w_ld_win) begin
                r_cmd   <= LOAD;
                r_addr  <= ld_req_addr;
                r_size  <= ld_req_size;
                r_wdata <= '0;
            end else if (w_st_done || w_ld_done) begin
                r_cmd <= NONE;
            end
        end
    end

`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [31:0] r_st_issued;
    logic [31:0] r_ld_issued;
    logic [31:0] r_st_wait_cycles;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_st_issued      <= '0;
            r_ld_issued      <= '0;
            r_st_wait_cycles <= '0;
        end else begin
            if (w_st_win) begin
                r_st_issued <= sat_inc32(r_st_issued);
            end
            if (w_ld_win) begin
                r_ld_issued <= sat_inc32(r_ld_issued);
            end
            if (w_store_ok && (w_ld_win || (r_state == ST_BUSY) || (r_state == LD_BUSY))) begin
                r_st_wait_cycles <= sat_inc32(r_st_wait_cycles);
            end
        end
    end

    assign st_issued      = r_st_issued;
    assign ld_issued      = r_ld_issued;
    assign st_wait_cycles = r_st_wait_cycles;
`endif

    // The pop coincides with the ack edge so the queue head has advanced before the next arbitration
    assign sq_pop         = w_st_done;
    assign ld_grant       = w_ld_win;
    assign ld_data_valid  = r_ld_data_valid;
    assign ld_data        = r_ld_data;
    assign mem_command    = r_cmd;
    assign mem_addr       = r_addr;
    assign mem_size       = r_size;
    assign mem_wdata      = r_wdata;
    assign pending_stores = w_pending;
    assign drained        = r_drained;
    assign overflow_err   = w_overflow;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios push expected memory
// transactions and load data; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N = 2, SQ_SZ = 8, STARVE_LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  num_store_retiring = '0;
    logic        halt_retired = 1'b0;
    logic        sq_head_valid = 1'b0;
    logic [31:0] sq_head_addr, sq_head_data;
    logic [1:0]  sq_head_size;
    logic        sq_pop;
    logic        ld_req_valid = 1'b0;
    logic [31:0] ld_req_addr = 32'h0000_2000;
    logic [1:0]  ld_req_size = 2'd2;
    logic        ld_grant, ld_data_valid;
    logic [31:0] ld_data;
    logic [1:0]  mem_command, mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  pending_stores;
    logic        drained, overflow_err;
`ifdef MEM_PORT_ARBITER_STATS_EN
    logic [31:0] st_issued, ld_issued, st_wait_cycles;
`endif

    always #5 clock = ~clock;

    mem_port_arbiter #(.N(N), .SQ_SZ(SQ_SZ), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock(clock), .reset(reset), .num_store_retiring(num_store_retiring),
        .halt_retired(halt_retired), .sq_head_valid(sq_head_valid), .sq_head_addr(sq_head_addr),
        .sq_head_data(sq_head_data), .sq_head_size(sq_head_size), .sq_pop(sq_pop),
        .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_size(ld_req_size),
        .ld_grant(ld_grant), .ld_data_valid(ld_data_valid), .ld_data(ld_data),
        .mem_command(mem_command), .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
`ifdef MEM_PORT_ARBITER_STATS_EN
        .st_issued(st_issued), .ld_issued(ld_issued), .st_wait_cycles(st_wait_cycles),
`endif
        .pending_stores(pending_stores), .drained(drained), .overflow_err(overflow_err)
    );

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_txn_q[$];
    logic [31:0] exp_ld_q[$];
    int checks = 0, errors = 0;
    int grants = 0;
    int sq_head = 0;

    // Store-queue model: entry k holds addr 0x1000+4k, data 0xD0000000+k, size k[1:0]
    assign sq_head_addr = 32'h0000_1000 + 32'(sq_head) * 32'd4;
    assign sq_head_data = 32'hD000_0000 + 32'(sq_head);
    assign sq_head_size = 2'(sq_head);

    function automatic txn_t st_txn(input int k);
        txn_t t;
        t.cmd   = 2'd2;
        t.addr  = 32'h0000_1000 + 32'(k) * 32'd4;
        t.size  = 2'(k);
        t.wdata = 32'hD000_0000 + 32'(k);
        return t;
    endfunction

    function automatic txn_t ld_txn();
        txn_t t;
        t.cmd   = 2'd1;
        t.addr  = 32'h0000_2000;
        t.size  = 2'd2;
        t.wdata = 32'h0;
        return t;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_issue(input string name, input int budget);
        int k = 0;
        while (mem_command == 2'd0 && k < budget) begin
            step();
            k++;
        end
        check(name, 128'(mem_command != 2'd0), 128'd1);
    endtask

    task automatic do_ack(input logic [31:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        num_store_retiring = '0;
        halt_retired = 1'b0;
        sq_head_valid = 1'b0;
        ld_req_valid = 1'b0;
        mem_ack = 1'b0;
        step(2);
        exp_txn_q.delete();
        exp_ld_q.delete();
        reset = 1'b1;
        step();
    endtask

    // Store-queue head advances one edge after a sampled pop
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                sq_head = 0;
            end else if (sq_pop) begin
                @(posedge clock);
                #1;
                sq_head++;
            end
        end
    end

    // Monitor: compares every newly issued transaction and every returned load datum
    initial begin
        logic [1:0]  prev_cmd;
        txn_t        t;
        logic [31:0] d;
        prev_cmd = 2'd0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_cmd = 2'd0;
            end else begin
                if (mem_command != 2'd0 && prev_cmd == 2'd0) begin
                    if (exp_txn_q.size() == 0) begin
                        check("txn_unexpected", 128'({mem_command, mem_addr}), 128'd0);
                    end else begin
                        t = exp_txn_q.pop_front();
                        check("txn", 128'({mem_command, mem_addr, mem_size, mem_wdata}), 128'(t));
                    end
                end
                prev_cmd = mem_command;
                if (ld_data_valid) begin
                    if (exp_ld_q.size() == 0) begin
                        check("ld_data_unexpected", 128'(ld_data), 128'hFFFF_FFFF_FFFF);
                    end else begin
                        d = exp_ld_q.pop_front();
                        check("ld_data", 128'(ld_data), 128'(d));
                    end
                end
                if (ld_grant) grants++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;

        // Reset state
        step(2);
        check("reset_outputs", 128'({sq_pop, ld_grant, ld_data_valid, ld_data, mem_command, mem_addr,
                                     mem_size, mem_wdata, pending_stores, drained, overflow_err}), 128'd0);
        reset = 1'b1;
        step();

        // Scenario 1: two stores retire, first is written, reset during the second
        num_store_retiring = 2'd2;
        sq_head_valid = 1'b1;
        exp_txn_q.push_back(st_txn(0));
        exp_txn_q.push_back(st_txn(1));
        step();
        num_store_retiring = 2'd0;
        check("s1_pending_2", 128'(pending_stores), 128'd2);
        check("s1_no_cmd_yet", 128'(mem_command), 128'd0);
        step();
        check("s1_store_issued", 128'(mem_command), 128'd2);
        step(2);
        check("s1_cmd_held", 128'(mem_command), 128'd2);
        mem_ack = 1'b1;
        #2;
        check("s1_sq_pop", 128'(sq_pop), 128'd1);
        step();
        mem_ack = 1'b0;
        check("s1_pending_1", 128'(pending_stores), 128'd1);
        check("s1_cmd_none", 128'({mem_command, sq_pop}), 128'd0);
        step();
        check("s1_store2_issued", 128'(mem_command), 128'd2);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("s1_async_reset", 128'({sq_pop, ld_grant, ld_data_valid, ld_data, mem_command, mem_addr,
                                      mem_size, mem_wdata, pending_stores, drained, overflow_err}), 128'd0);
        apply_reset();

        // Scenario 2: four loads starve one store, then the store wins
        num_store_retiring = 2'd1;
        step();
        num_store_retiring = 2'd0;
        g0 = grants;
        sq_head_valid = 1'b1;
        ld_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_txn_q.push_back(ld_txn());
            exp_ld_q.push_back(32'hBEEF_0000 + 32'(i));
            wait_issue("s2_ld_issue", 10);
            do_ack(32'hBEEF_0000 + 32'(i));
        end
        exp_txn_q.push_back(st_txn(0));
        wait_issue("s2_st_issue", 10);
        check("s2_store_after_starve", 128'(mem_command), 128'd2);
        check("s2_grant_count", 128'(grants - g0), 128'd4);
        check("s2_starve_cleared", 128'(dut.w_starve), 128'd0);
        ld_req_valid = 1'b0;
        do_ack(32'h0);
        check("s2_pending_0", 128'(pending_stores), 128'd0);
        apply_reset();

        // Scenario 3: retire and store completion in the same cycle
        num_store_retiring = 2'd2;
        step();
        num_store_retiring = 2'd1;
        step();
        num_store_retiring = 2'd0;
        check("s3_pending_3", 128'(pending_stores), 128'd3);
        exp_txn_q.push_back(st_txn(0));
        sq_head_valid = 1'b1;
        wait_issue("s3_st_issue", 10);
        mem_ack = 1'b1;
        num_store_retiring = 2'd1;
        #2;
        check("s3_sq_pop", 128'(sq_pop), 128'd1);
        step();
        mem_ack = 1'b0;
        num_store_retiring = 2'd0;
        sq_head_valid = 1'b0;
        check("s3_pending_still_3", 128'(pending_stores), 128'd3);
        apply_reset();

        // Scenario 4: overflow clamps at SQ_SZ and sticks
        num_store_retiring = 2'd2;
        step(4);
        check("s4_pending_8_no_ovf", 128'({pending_stores, overflow_err}), 128'({4'd8, 1'b0}));
        step();
        num_store_retiring = 2'd0;
        check("s4_pending_8_ovf", 128'({pending_stores, overflow_err}), 128'({4'd8, 1'b1}));
        step(3);
        check("s4_ovf_sticky", 128'({pending_stores, overflow_err}), 128'({4'd8, 1'b1}));
        apply_reset();

        // Scenario 5: halt with a pending load; both stores drain, then drained
        num_store_retiring = 2'd2;
        step();
        num_store_retiring = 2'd0;
        exp_txn_q.push_back(st_txn(0));
        exp_txn_q.push_back(st_txn(1));
        g0 = grants;
        sq_head_valid = 1'b1;
        ld_req_valid = 1'b1;
        halt_retired = 1'b1;
        #2;
        check("s5_no_grant_on_halt", 128'(ld_grant), 128'd0);
        step();
        halt_retired = 1'b0;
        wait_issue("s5_st1_issue", 10);
        do_ack(32'h0);
        wait_issue("s5_st2_issue", 10);
        do_ack(32'h0);
        check("s5_pending_0_not_drained", 128'({pending_stores, drained}), 128'd0);
        step();
        check("s5_drained", 128'({drained, mem_command}), 128'({1'b1, 2'd0}));
        step(3);
        check("s5_drained_stays", 128'({drained, mem_command}), 128'({1'b1, 2'd0}));
        check("s5_no_load_grants", 128'(grants - g0), 128'd0);
`ifdef MEM_PORT_ARBITER_STATS_EN
        check("stats_st_issued", 128'(st_issued), 128'd2);
        check("stats_ld_issued", 128'(ld_issued), 128'd0);
        check("stats_st_wait", 128'(st_wait_cycles), 128'd2);
`endif
        check("txn_queue_empty", 128'(exp_txn_q.size()), 128'd0);
        check("ld_queue_empty", 128'(exp_ld_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
